// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit register file with two operand read ports, a debug
// read port and a committed-write counter. Register 0 is hard-wired to zero.
// Optional feature macro: REGFILE_BYPASS_EN forwards the in-flight write data
// onto rs_data/rt_data in the same cycle. The debug port and all state are the
// same in both builds.
module reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] wd,
    input  logic        we,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic [15:0] wr_count
);

    logic [31:0] regFile_q [32];
    logic [15:0] wrCount_q;
    logic [15:0] wrCount_d;
    logic        commit;
    logic [31:0] rsStored;
    logic [31:0] rtStored;

    // Writes to register 0 are dropped entirely, including the count.
    assign commit    = we && (rd_addr != 5'd0);
    assign wrCount_d = wrCount_q + 16'd1;

    // Storage and write counter; reset clears everything without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regFile_q[i] <= '0;
            end
            wrCount_q <= '0;
        end else if (commit) begin
            regFile_q[rd_addr] <= wd;
            wrCount_q          <= wrCount_d;
        end
    end

    // Combinational reads of the stored contents, with register 0 forced to zero.
    always_comb begin
        rsStored = (rs_addr == 5'd0) ? 32'h0 : regFile_q[rs_addr];
        rtStored = (rt_addr == 5'd0) ? 32'h0 : regFile_q[rt_addr];
        dbg_data = (dbg_addr == 5'd0) ? 32'h0 : regFile_q[dbg_addr];
    end

`ifdef REGFILE_BYPASS_EN
    // Operand ports see the pending write data; suppressed while in reset.
    always_comb begin
        rs_data = rsStored;
        rt_data = rtStored;
        if (!rst && commit && (rd_addr == rs_addr)) begin
            rs_data = wd;
        end
        if (!rst && commit && (rd_addr == rt_addr)) begin
            rt_data = wd;
        end
    end
`else
    assign rs_data = rsStored;
    assign rt_data = rtStored;
`endif

    assign wr_count = wrCount_q;

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file: scoreboard of expected port values driven by a
// behavioural array model; a monitor compares once per cycle between edges.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [15:0] wr_count;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] dbg;
        logic [15:0] cnt;
        string       tag;
    } expect_t;

    expect_t     scoreQ[$];
    logic [31:0] modelRegs [32];
    logic [15:0] modelCount;
    int          checks;
    int          errors;

    reg_file dut (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rd_addr  (rd_addr),
        .wd       (wd),
        .we       (we),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_count (wr_count)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Expected value of an operand port given the architectural register rules.
    function automatic logic [31:0] portValue(input logic r, input logic [4:0] a, input logic [4:0] d,
                                              input logic [31:0] data, input logic w);
        if (r) return 32'h0;
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (w && d != 5'd0 && d == a) return data;
`endif
        return modelRegs[a];
    endfunction

    // Drive one cycle of inputs (called just after a rising edge), queue the
    // expected mid-cycle outputs, then advance the model across the next edge.
    task automatic applyStimulus(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [4:0] dbg,
                                 input logic [31:0] data, input logic w, input string tag);
        expect_t e;
        rst = r; rs_addr = rs; rt_addr = rt; rd_addr = rd; dbg_addr = dbg; wd = data; we = w;
        if (r) begin
            for (int i = 0; i < 32; i++) modelRegs[i] = 32'h0;
            modelCount = 16'h0;
        end
        e.rs  = portValue(r, rs, rd, data, w);
        e.rt  = portValue(r, rt, rd, data, w);
        e.dbg = r ? 32'h0 : ((dbg == 5'd0) ? 32'h0 : modelRegs[dbg]);
        e.cnt = modelCount;
        e.tag = tag;
        scoreQ.push_back(e);
        @(posedge clk);
        if (!r && w && rd != 5'd0) begin
            modelRegs[rd] = data;
            modelCount    = modelCount + 16'd1;
        end
        #1;
    endtask

    // Monitor: every falling edge the DUT outputs are settled; pop and compare.
    always @(negedge clk) begin
        expect_t e;
        if (scoreQ.size() > 0) begin
            e = scoreQ.pop_front();
            checkOutput({"rs_data/", e.tag}, rs_data, e.rs);
            checkOutput({"rt_data/", e.tag}, rt_data, e.rt);
            checkOutput({"dbg_data/", e.tag}, dbg_data, e.dbg);
            checkOutput({"wr_count/", e.tag}, {16'h0, wr_count}, {16'h0, e.cnt});
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        modelCount = 16'h0;
        for (int i = 0; i < 32; i++) modelRegs[i] = 32'h0;
        rst = 1'b1; rs_addr = '0; rt_addr = '0; rd_addr = '0; dbg_addr = '0; wd = '0; we = 1'b0;
        @(posedge clk);
        #1;

        // Reset then read.
        applyStimulus(1'b1, 5'd5, 5'd31, 5'd0, 5'd17, 32'h0, 1'b0, "in_reset");
        applyStimulus(1'b0, 5'd5, 5'd31, 5'd0, 5'd17, 32'h0, 1'b0, "reset_read");

        // Write then read back on both ports.
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd3, 5'd3, 32'hDEADBEEF, 1'b1, "write_r3");
        applyStimulus(1'b0, 5'd3, 5'd3, 5'd0, 5'd3, 32'h0, 1'b0, "read_r3");

        // Register 0 protection.
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, "write_r0");
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, "read_r0");

        // Same-cycle write/read on register 7.
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd7, 5'd0, 32'h11111111, 1'b1, "write_r7");
        applyStimulus(1'b0, 5'd7, 5'd7, 5'd7, 5'd7, 32'h22222222, 1'b1, "bypass_r7");
        applyStimulus(1'b0, 5'd7, 5'd7, 5'd0, 5'd7, 32'h0, 1'b0, "after_r7");

        // Async reset mid-cycle with a pending write, then first write after release.
        applyStimulus(1'b0, 5'd9, 5'd9, 5'd9, 5'd9, 32'h12345678, 1'b1, "write_r9");
        applyStimulus(1'b0, 5'd9, 5'd9, 5'd0, 5'd9, 32'h0, 1'b0, "read_r9");
        applyStimulus(1'b1, 5'd9, 5'd9, 5'd9, 5'd9, 32'hCAFEF00D, 1'b1, "reset_r9");
        applyStimulus(1'b0, 5'd9, 5'd9, 5'd4, 5'd9, 32'hA5A5A5A5, 1'b1, "first_write");
        applyStimulus(1'b0, 5'd9, 5'd4, 5'd0, 5'd4, 32'h0, 1'b0, "after_first");

        // Randomised traffic with small address range to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          $urandom, ($urandom_range(0, 3) != 0), "random");
        end

        // Counter wrap: 65536 committed writes from reset return to zero.
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, "wrap_reset");
        for (int n = 0; n < 65536; n++) begin
            applyStimulus(1'b0, 5'd1, 5'd2, 5'(1 + (n % 31)), 5'd3, $urandom, 1'b1, "wrap_fill");
        end
        checkOutput("wrap_zero", {16'h0, wr_count}, 32'h0);
        applyStimulus(1'b0, 5'd1, 5'd2, 5'd12, 5'd3, 32'h0BADC0DE, 1'b1, "wrap_one");
        checkOutput("wrap_one", {16'h0, wr_count}, 32'h1);
        applyStimulus(1'b0, 5'd12, 5'd0, 5'd0, 5'd12, 32'h0, 1'b0, "wrap_read");

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 4 && scoreQ.size() > 0; k++) @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(scoreQ.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rs_addr  input  5  read port 1 address; its data drives ALU operand A.
REQ-005 rt_addr  input  5  read port 2 address; its data drives ALU operand B.
REQ-006 rd_addr  input  5  write address.
REQ-007 wd  input  32  write data, normally the ALU result or the load data.
REQ-008 we  input  1  write enable.
REQ-009 rs_data  output  32  read port 1 data.
REQ-010 rt_data  output  32  read port 2 data.
REQ-011 dbg_addr  input  5  debug/display read address.
REQ-012 dbg_data  output  32  debug read data; this port SHALL never bypass.
REQ-013 wr_count  output  16  count of committed writes.

Function
REQ-014 The block SHALL hold 32 x 32-bit registers; register 0 SHALL always read 0x00000000 on every port.
REQ-015 Reads SHALL be combinational with zero-cycle latency; rs_data, rt_data and dbg_data SHALL change in the same cycle as their address.
REQ-016 A committed write SHALL be we=1 AND rd_addr!=0 at a rising clk edge with rst low; it SHALL store wd into register rd_addr.
REQ-017 A write with rd_addr=0 SHALL be discarded and SHALL NOT increment wr_count.
REQ-018 wr_count SHALL increment by 1 on each committed write and wrap from 0xFFFF to 0x0000.
REQ-019 When rs_addr equals rt_addr, both ports SHALL return identical data.
REQ-020 Write-after-read ordering: a read in the cycle of a write SHALL follow REQ-030/REQ-031; the stored value SHALL be visible on every port from the cycle after the edge.
REQ-021 There SHALL be no stall or handshake; one write per cycle SHALL be sustained indefinitely.

Reset
REQ-022 Assertion of rst SHALL immediately, without waiting for clk, clear all registers to 0 and wr_count to 0.
REQ-023 While rst is high, every clk edge SHALL be ignored, including writes and counting.
REQ-024 When rst is asserted in the same cycle as a pending write, reset SHALL win and the write SHALL be lost.
REQ-025 During reset, rs_data, rt_data and dbg_data SHALL read 0x00000000.
REQ-026 The first committed write SHALL be taken at the first rising edge on which rst is sampled low.

Configuration
REQ-027 The macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-028 The macro SHALL affect only rs_data and rt_data; storage, wr_count and dbg_data SHALL be identical in both builds.
REQ-029 Forwarding SHALL never apply for rd_addr=0.
REQ-030 With REGFILE_BYPASS_EN defined: when we=1, rd_addr!=0 and rd_addr equals rs_addr (or rt_addr), that port SHALL output wd combinationally in the same cycle.
REQ-031 With REGFILE_BYPASS_EN undefined: those ports SHALL output the stored (old) value until the edge.

Verification
REQ-032 Reset then read: pulse rst, then read rs=5, rt=31, dbg=17 -> all 0x00000000; wr_count=0.
REQ-033 Write then read: we=1, rd=3, wd=0xDEADBEEF for one edge; next cycle rs=3, rt=3 -> both 0xDEADBEEF; wr_count=1.
REQ-034 Register 0 protection: write rd=0, wd=0xFFFFFFFF -> rs_addr=0 reads 0x00000000; wr_count unchanged.
REQ-035 Same-cycle bypass: reg 7=0x11111111; drive we=1, rd=7, wd=0x22222222, rs=7 before the edge.
- With the macro defined: rs_data=0x22222222 before the edge.
- Without the macro: rs_data=0x11111111 before the edge.
- In both builds: dbg_data with dbg_addr=7 reads 0x11111111 before the edge.
REQ-036 Async reset mid-operation: write 0x12345678 to reg 9, then assert rst between edges -> rs_data for reg 9 reads 0 before the next edge; a write issued with rst high is lost.
REQ-037 Counter wrap: perform 65536 committed writes -> wr_count=0x0000; one more write -> wr_count=0x0001.
